// File: rtl/branch_resolve_ctrl_pkg.sv
// Shared opcode constants, FSM state encoding and branch-decode helpers
// for the ID-stage branch resolution controller.
package branch_resolve_ctrl_pkg;

   localparam logic [5:0] OP_REGIMM = 6'b000001;
   localparam logic [5:0] OP_BEQ    = 6'b000100;
   localparam logic [5:0] OP_BNE    = 6'b000101;
   localparam logic [5:0] OP_BLEZ   = 6'b000110;
   localparam logic [5:0] OP_BGTZ   = 6'b000111;

   localparam logic [4:0] RI_BLTZ   = 5'b00000;
   localparam logic [4:0] RI_BGEZ   = 5'b00001;
   localparam logic [4:0] RI_BLTZAL = 5'b10000;
   localparam logic [4:0] RI_BGEZAL = 5'b10001;

   typedef enum logic [1:0] {
      BR_IDLE     = 2'd0,
      BR_WAIT     = 2'd1,
      BR_RESOLVE  = 2'd2,
      BR_REDIRECT = 2'd3
   } br_state_e;

   function automatic logic is_branch(input logic [5:0] op, input logic [4:0] rt);
      logic r;
      r = 1'b0;
      case (op)
         OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: r = 1'b1;
         OP_REGIMM: r = (rt == RI_BLTZ) || (rt == RI_BGEZ) ||
                        (rt == RI_BLTZAL) || (rt == RI_BGEZAL);
         default: r = 1'b0;
      endcase
      return r;
   endfunction

   function automatic logic is_link(input logic [5:0] op, input logic [4:0] rt);
      return (op == OP_REGIMM) && ((rt == RI_BLTZAL) || (rt == RI_BGEZAL));
   endfunction

   // Only the two-operand compares read rt as a register.
   function automatic logic uses_rt(input logic [5:0] op);
      return (op == OP_BEQ) || (op == OP_BNE);
   endfunction

endpackage

// File: rtl/branch_resolve_ctrl_br_cond.sv
// Combinational branch condition evaluator: a is the rs operand, b the rt
// operand; sign tests use the MSB directly.
module br_cond
   import branch_resolve_ctrl_pkg::*;
#(
   parameter int DW = 32
) (
   input  logic [5:0]    op,
   input  logic [4:0]    rt,
   input  logic [DW-1:0] a,
   input  logic [DW-1:0] b,
   output logic          taken
);

   logic a_neg;
   logic a_zero;

   assign a_neg  = a[DW-1];
   assign a_zero = (a == '0);

   always_comb begin
      taken = 1'b0;
      case (op)
         OP_BEQ:  taken = (a == b);
         OP_BNE:  taken = (a != b);
         OP_BGTZ: taken = !a_neg && !a_zero;
         OP_BLEZ: taken = a_neg || a_zero;
         OP_REGIMM: begin
            case (rt)
               RI_BLTZ, RI_BLTZAL: taken = a_neg;
               RI_BGEZ, RI_BGEZAL: taken = !a_neg;
               default:            taken = 1'b0;
            endcase
         end
         default: taken = 1'b0;
      endcase
   end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// Holds a conditional branch in ID until its operands are hazard-free,
// resolves it, then issues a one-cycle PC redirect and optional r31 link write.
module branch_resolve_ctrl
   import branch_resolve_ctrl_pkg::*;
#(
   parameter int DW = 32,
   parameter int RW = 5
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic          id_valid,
   input  logic [5:0]    id_op,
   input  logic [RW-1:0] id_rt,
   input  logic [RW-1:0] id_rs_addr,
   input  logic [RW-1:0] id_rt_addr,
   input  logic [DW-1:0] id_rs_data,
   input  logic [DW-1:0] id_rt_data,
   input  logic [DW-1:0] id_pc_plus4,
   input  logic [15:0]   id_imm,
   input  logic          ex_wr_en,
   input  logic [RW-1:0] ex_wr_addr,
   input  logic          mem_wr_en,
   input  logic [RW-1:0] mem_wr_addr,
   input  logic          mem_is_load,
   input  logic [DW-1:0] mem_wr_data,
   output logic          stall_id,
   output logic          br_taken,
   output logic [DW-1:0] br_target,
   output logic          link_we,
   output logic [DW-1:0] link_data,
   output logic          busy
);

   br_state_e     state_q, state_d;
   logic          taken_q, taken_d;
   logic          link_q, link_d;
   logic [DW-1:0] br_target_q, br_target_d;
   logic [DW-1:0] link_data_q, link_data_d;

   logic          valid_br;
   logic          rs_hz, rt_hz, hz;
   logic          rs_fwd, rt_fwd;
   logic [DW-1:0] rs_op, rt_op;
   logic [DW-1:0] target;
   logic          cond;

   // Gated by resetn so stall_id is already low while reset is held.
   assign valid_br = resetn && id_valid && is_branch(id_op, id_rt);

   // An EX producer or a MEM load cannot be forwarded yet: wait it out.
   assign rs_hz = (id_rs_addr != '0) &&
                  ((ex_wr_en && (ex_wr_addr == id_rs_addr)) ||
                   (mem_wr_en && mem_is_load && (mem_wr_addr == id_rs_addr)));
   assign rt_hz = uses_rt(id_op) && (id_rt_addr != '0) &&
                  ((ex_wr_en && (ex_wr_addr == id_rt_addr)) ||
                   (mem_wr_en && mem_is_load && (mem_wr_addr == id_rt_addr)));
   assign hz    = rs_hz || rt_hz;

   assign rs_fwd = (id_rs_addr != '0) && mem_wr_en && (mem_wr_addr == id_rs_addr);
   assign rt_fwd = (id_rt_addr != '0) && mem_wr_en && (mem_wr_addr == id_rt_addr);
   assign rs_op  = rs_fwd ? mem_wr_data : id_rs_data;
   assign rt_op  = rt_fwd ? mem_wr_data : id_rt_data;

   assign target = id_pc_plus4 + {{(DW-18){id_imm[15]}}, id_imm, 2'b00};

   br_cond #(.DW(DW)) u_br_cond (
      .op    (id_op),
      .rt    (id_rt),
      .a     (rs_op),
      .b     (rt_op),
      .taken (cond)
   );

   always_comb begin
      state_d     = state_q;
      taken_d     = taken_q;
      link_d      = link_q;
      br_target_d = br_target_q;
      link_data_d = link_data_q;
      stall_id    = 1'b0;
      br_taken    = 1'b0;
      link_we     = 1'b0;
      case (state_q)
         BR_IDLE: begin
            if (valid_br) begin
               stall_id = 1'b1;
               state_d  = hz ? BR_WAIT : BR_RESOLVE;
            end
         end
         BR_WAIT: begin
            stall_id = 1'b1;
            if (!hz) state_d = BR_RESOLVE;
         end
         BR_RESOLVE: begin
            stall_id    = 1'b1;
            taken_d     = cond;
            link_d      = is_link(id_op, id_rt);
            br_target_d = target;
            link_data_d = id_pc_plus4 + {{(DW-3){1'b0}}, 3'd4};
            state_d     = BR_REDIRECT;
         end
         BR_REDIRECT: begin
            // ID is released here; the delay slot enters ID next cycle.
            br_taken = taken_q;
            link_we  = link_q;
            state_d  = BR_IDLE;
         end
         default: state_d = BR_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q     <= BR_IDLE;
         taken_q     <= 1'b0;
         link_q      <= 1'b0;
         br_target_q <= '0;
         link_data_q <= '0;
      end else begin
         state_q     <= state_d;
         taken_q     <= taken_d;
         link_q      <= link_d;
         br_target_q <= br_target_d;
         link_data_q <= link_data_d;
      end
   end

   assign br_target = br_target_q;
   assign link_data = link_data_q;
   assign busy      = (state_q != BR_IDLE);

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Directed bench for branch_resolve_ctrl: a per-cycle reference model plus
// hand-computed expectations at the key points of each scenario.
module tb_branch_resolve_ctrl;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        id_valid = 1'b0;
   logic [5:0]  id_op = '0;
   logic [4:0]  id_rt = '0;
   logic [4:0]  id_rs_addr = '0, id_rt_addr = '0;
   logic [31:0] id_rs_data = '0, id_rt_data = '0, id_pc_plus4 = '0;
   logic [15:0] id_imm = '0;
   logic        ex_wr_en = 1'b0;
   logic [4:0]  ex_wr_addr = '0;
   logic        mem_wr_en = 1'b0, mem_is_load = 1'b0;
   logic [4:0]  mem_wr_addr = '0;
   logic [31:0] mem_wr_data = '0;
   logic        stall_id, br_taken, link_we, busy;
   logic [31:0] br_target, link_data;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   branch_resolve_ctrl #(.DW(32), .RW(5)) dut (
      .clk(clk), .resetn(resetn), .id_valid(id_valid), .id_op(id_op), .id_rt(id_rt),
      .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr), .id_rs_data(id_rs_data),
      .id_rt_data(id_rt_data), .id_pc_plus4(id_pc_plus4), .id_imm(id_imm),
      .ex_wr_en(ex_wr_en), .ex_wr_addr(ex_wr_addr), .mem_wr_en(mem_wr_en),
      .mem_wr_addr(mem_wr_addr), .mem_is_load(mem_is_load), .mem_wr_data(mem_wr_data),
      .stall_id(stall_id), .br_taken(br_taken), .br_target(br_target),
      .link_we(link_we), .link_data(link_data), .busy(busy)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic bit m_is_br(input logic [5:0] op, input logic [4:0] rt);
      if (op inside {6'd4, 6'd5, 6'd6, 6'd7}) return 1'b1;
      return (op == 6'd1) && (rt inside {5'd0, 5'd1, 5'd16, 5'd17});
   endfunction

   function automatic bit m_blocked(input logic [4:0] r);
      if (r == 0) return 1'b0;
      if (ex_wr_en && ex_wr_addr == r) return 1'b1;
      return mem_wr_en && mem_is_load && mem_wr_addr == r;
   endfunction

   function automatic logic [31:0] m_val(input logic [4:0] r, input logic [31:0] rf);
      if (r != 0 && mem_wr_en && mem_wr_addr == r) return mem_wr_data;
      return rf;
   endfunction

   function automatic bit m_cond(input logic [5:0] op, input logic [4:0] rt,
                                 input logic [31:0] a, input logic [31:0] b);
      int sa;
      sa = int'($signed(a));
      case (op)
         6'd4:    return a == b;
         6'd5:    return a != b;
         6'd7:    return sa > 0;
         6'd6:    return sa <= 0;
         default: return (rt == 5'd0 || rt == 5'd16) ? (sa < 0) : (sa >= 0);
      endcase
   endfunction

   function automatic logic [31:0] m_target(input logic [31:0] pc4, input logic [15:0] imm);
      longint t;
      t = longint'(pc4) + longint'($signed(imm)) * 4;
      return t[31:0];
   endfunction

   // phase: 0 no branch held, 1 waiting on a producer, 2 resolving, 3 redirecting
   int          m_phase = 0, n_phase;
   bit          m_taken = 0, m_link = 0, n_taken, n_link;
   logic [31:0] m_tgt = '0, m_ld = '0, n_tgt, n_ld;

   initial begin
      forever begin
         @(negedge clk);
         if (!resetn) begin
            m_phase = 0; m_taken = 0; m_link = 0; m_tgt = '0; m_ld = '0;
         end
         begin
            bit vb, blk;
            vb  = resetn && id_valid && m_is_br(id_op, id_rt);
            blk = m_blocked(id_rs_addr) ||
                  ((id_op == 6'd4 || id_op == 6'd5) && m_blocked(id_rt_addr));
            chk("stall_id", stall_id, (m_phase == 0 && vb) || m_phase == 1 || m_phase == 2);
            chk("busy", busy, m_phase != 0);
            chk("br_taken", br_taken, m_phase == 3 && m_taken);
            chk("link_we", link_we, m_phase == 3 && m_link);
            chk("br_target", br_target, m_tgt);
            chk("link_data", link_data, m_ld);
            n_phase = 0; n_taken = m_taken; n_link = m_link; n_tgt = m_tgt; n_ld = m_ld;
            if (m_phase == 0 && vb)   n_phase = blk ? 1 : 2;
            else if (m_phase == 1)    n_phase = blk ? 1 : 2;
            else if (m_phase == 2) begin
               n_phase = 3;
               n_taken = m_cond(id_op, id_rt, m_val(id_rs_addr, id_rs_data),
                                m_val(id_rt_addr, id_rt_data));
               n_link  = (id_op == 6'd1) && (id_rt == 5'd16 || id_rt == 5'd17);
               n_tgt   = m_target(id_pc_plus4, id_imm);
               n_ld    = id_pc_plus4 + 32'd4;
            end
         end
         @(posedge clk);
         if (resetn) begin
            m_phase = n_phase; m_taken = n_taken; m_link = n_link;
            m_tgt = n_tgt; m_ld = n_ld;
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic nxt();
      @(posedge clk); #1;
   endtask

   task automatic idle();
      id_valid = 1'b0; ex_wr_en = 1'b0; mem_wr_en = 1'b0; mem_is_load = 1'b0;
   endtask

   task automatic br(input logic [5:0] op, input logic [4:0] rt, input logic [4:0] rsa,
                     input logic [4:0] rta, input logic [31:0] rsd, input logic [31:0] rtd,
                     input logic [31:0] pc4, input logic [15:0] imm);
      id_valid = 1'b1; id_op = op; id_rt = rt; id_rs_addr = rsa; id_rt_addr = rta;
      id_rs_data = rsd; id_rt_data = rtd; id_pc_plus4 = pc4; id_imm = imm;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      repeat (2) @(negedge clk);
      chk("rst stall_id", stall_id, 0);
      chk("rst br_target", br_target, 0);
      chk("rst busy", busy, 0);
      nxt(); resetn = 1'b1;
      nxt();

      // BEQ equal, no hazard: stall N, N+1; redirect N+2
      br(6'd4, 5'd1, 5'd1, 5'd2, 32'h5, 32'h5, 32'h0000_1000, 16'd4);
      @(negedge clk); chk("beq N stall", stall_id, 1); chk("beq N busy", busy, 0);
      nxt(); @(negedge clk); chk("beq N+1 stall", stall_id, 1);
      nxt(); @(negedge clk);
      chk("beq taken", br_taken, 1); chk("beq target", br_target, 32'h0000_1010);
      chk("beq stall drop", stall_id, 0);
      nxt(); idle(); nxt();

      // BNE on equal values: not taken
      br(6'd5, 5'd0, 5'd3, 5'd4, 32'hA, 32'hA, 32'h0000_2000, 16'd8);
      nxt(); nxt(); @(negedge clk);
      chk("bne taken", br_taken, 0); chk("bne stall", stall_id, 0);
      nxt(); idle(); nxt();

      // BGTZ: EX producer, then MEM load next cycle -> two WAIT cycles
      br(6'd7, 5'd0, 5'd6, 5'd0, 32'h7, 32'h0, 32'h0000_2000, 16'hFFFF);
      ex_wr_en = 1'b1; ex_wr_addr = 5'd6;
      nxt(); ex_wr_en = 1'b0;
      mem_wr_en = 1'b1; mem_wr_addr = 5'd6; mem_is_load = 1'b1; mem_wr_data = 32'hDEAD_0000;
      @(negedge clk); chk("bgtz wait1 stall", stall_id, 1);
      nxt(); mem_wr_en = 1'b0; mem_is_load = 1'b0;
      @(negedge clk); chk("bgtz wait2 busy", busy, 1);
      nxt(); @(negedge clk); chk("bgtz resolve stall", stall_id, 1); chk("bgtz no early", br_taken, 0);
      nxt(); @(negedge clk);
      chk("bgtz taken", br_taken, 1); chk("bgtz target", br_target, 32'h0000_1FFC);
      nxt(); idle(); nxt();

      // BLTZAL with rs forwarded from a MEM ALU result
      br(6'd1, 5'd16, 5'd3, 5'd0, 32'h0, 32'h0, 32'h0040_0004, 16'd2);
      mem_wr_en = 1'b1; mem_wr_addr = 5'd3; mem_is_load = 1'b0; mem_wr_data = 32'h8000_0000;
      nxt(); nxt(); @(negedge clk);
      chk("bltzal taken", br_taken, 1); chk("bltzal link_we", link_we, 1);
      chk("bltzal link_data", link_data, 32'h0040_0008);
      chk("bltzal target", br_target, 32'h0040_000C);
      nxt(); idle(); nxt();

      // BGEZ with the most negative offset: target wraps
      br(6'd1, 5'd1, 5'd4, 5'd0, 32'h1, 32'h0, 32'h0000_0010, 16'h8000);
      nxt(); nxt(); @(negedge clk);
      chk("bgez target", br_target, 32'hFFFE_0010); chk("bgez taken", br_taken, 1);
      chk("bgez link_we", link_we, 0);
      nxt(); idle(); nxt();

      // BGTZ ignores an EX producer on rt_addr; non-branches never stall
      br(6'd7, 5'd0, 5'd5, 5'd9, 32'h3, 32'h0, 32'h0000_0100, 16'd1);
      ex_wr_en = 1'b1; ex_wr_addr = 5'd9;
      nxt(); nxt(); @(negedge clk); chk("bgtz rt no hz", br_taken, 1);
      nxt(); idle();
      br(6'h23, 5'd0, 5'd1, 5'd2, 32'h0, 32'h0, 32'h0, 16'd0);
      @(negedge clk); chk("lw no stall", stall_id, 0);
      br(6'd1, 5'd2, 5'd1, 5'd2, 32'h0, 32'h0, 32'h0, 16'd0);
      nxt(); @(negedge clk); chk("regimm other busy", busy, 0);
      idle(); nxt();

      // Reset while waiting aborts the branch
      br(6'd4, 5'd0, 5'd7, 5'd8, 32'h1, 32'h1, 32'h0000_3000, 16'd3);
      ex_wr_en = 1'b1; ex_wr_addr = 5'd8;
      nxt(); nxt(); resetn = 1'b0; #1;
      chk("rst-wait stall", stall_id, 0); chk("rst-wait busy", busy, 0);
      chk("rst-wait target", br_target, 0);
      nxt(); resetn = 1'b1; idle();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); chk("post-rst no pulse", br_taken | link_we, 0);
         nxt();
      end

      // Next branch after reset resolves normally: BLEZ on r0
      br(6'd6, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0000_4000, 16'hFFFE);
      ex_wr_en = 1'b1; ex_wr_addr = 5'd0;
      nxt(); nxt(); @(negedge clk);
      chk("blez taken", br_taken, 1); chk("blez target", br_target, 32'h0000_3FF8);
      nxt(); idle();
      repeat (3) nxt();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/branch_resolve_ctrl.md
# branch_resolve_ctrl

Sequences branch resolution in the ID stage of the five-stage MIPS pipeline. Each conditional branch is held in ID until its operands are hazard-free, then resolved through a forwarding mux and a condition evaluator. The block drives the PC redirect and the BLTZAL/BGEZAL link write request. It replaces ad-hoc stall logic around the branch comparator with an explicit state machine.

## Interface
- `DW`, 32, datapath width
- `RW`, 5, register address width
- `clk`  in  1  pipeline clock, rising edge
- `resetn`  in  1  asynchronous, active-low reset
- `id_valid`  in  1  instruction in ID is valid
- `id_op`  in  6  opcode field
- `id_rt`  in  RW  rt field (REGIMM sub-op)
- `id_rs_addr`, `id_rt_addr`  in  RW  source register numbers
- `id_rs_data`, `id_rt_data`  in  DW  register-file read data
- `id_pc_plus4`  in  DW  PC of branch + 4
- `id_imm`  in  16  branch offset
- `ex_wr_en`, `ex_wr_addr`  in  1/RW  EX-stage producer
- `mem_wr_en`, `mem_wr_addr`, `mem_is_load`, `mem_wr_data`  in  1/RW/1/DW  MEM-stage producer
- `stall_id`  out  1  hold PC and IF/ID
- `br_taken`  out  1  redirect PC (one-cycle pulse)
- `br_target`  out  DW  redirect address
- `link_we`  out  1  write r31 (one-cycle pulse)
- `link_data`  out  DW  `id_pc_plus4` + 4
- `busy`  out  1  state != IDLE

## Operation
- Branch ops, from `defines.vh`: BEQ, BNE, BGTZ, BLEZ, and REGIMM with rt = 00000 BLTZ, 00001 BGEZ, 10000 BLTZAL, 10001 BGEZAL. All other ops are ignored and stay in IDLE.
- Conditions: BEQ a==b; BNE a!=b; BGTZ signed a>0; BLEZ signed a<=0; BLTZ/BLTZAL a<0; BGEZ/BGEZAL a>=0. a is the rs operand and b is the rt operand.
- Operand hazard for a source s (rt is checked only for BEQ/BNE). Register 0 never hazards.
  - WAIT if `ex_wr_en` and `ex_wr_addr`==s.
  - Else WAIT if `mem_wr_en`, `mem_wr_addr`==s and `mem_is_load`.
  - Else forward `mem_wr_data` if the MEM stage writes s.
  - Else use the register-file data.
- FSM states:
  - IDLE: on a valid branch, go to RESOLVE if no hazard, else WAIT.
  - WAIT: re-check hazards every cycle; go to RESOLVE when clear.
  - RESOLVE: capture the forwarded operands and the condition result into registers, then go to REDIRECT.
  - REDIRECT: drive `br_taken` = registered condition and `link_we` = 1 for the AL forms, for one cycle, then go to IDLE.
- Target = `id_pc_plus4` + (sign-extended `id_imm` << 2), modulo 2^32 (wraps).
- The link write happens regardless of the branch outcome.
- `stall_id` = (IDLE and valid branch) or WAIT or RESOLVE. It deasserts in REDIRECT so ID advances at the end of that cycle.
- The delay slot is preserved; no IF flush.
- While in REDIRECT, `id_valid` is ignored (same instruction).

## Timing
- Reset, asynchronous while `resetn`=0: state IDLE; all outputs 0 (`stall_id`, `br_taken`, `br_target`, `link_we`, `link_data`, `busy`).
- Reset during WAIT, RESOLVE or REDIRECT aborts the branch; no redirect or link pulse is issued afterward.
- With no hazard, a branch arriving at cycle N is stalled in N and N+1, and redirects in N+2.
- Each WAIT cycle adds one cycle to the stall.
- `br_target` and `link_data` are registered in RESOLVE and held until the next RESOLVE.
- A producer leaving EX in the same cycle that WAIT re-checks is seen through the MEM-stage terms on the next cycle.

## Structure
- `defines.vh` holds the opcode/REGIMM constants, `ZeroWord`, and the state encodings `BR_IDLE`/`BR_WAIT`/`BR_RESOLVE`/`BR_REDIRECT`.
- One combinational sub-module, `br_cond` (op, rt, a, b → taken), is instantiated once.

## Test plan
- BEQ, rs=rt=0x5, no hazard → stall for 2 cycles; `br_taken`=1 with `br_target` = pc_plus4 + 0x10 for `id_imm`=4.
- BNE on equal values (0xA, 0xA) → `br_taken`=0 in REDIRECT; `stall_id` drops.
- BGTZ with EX writing rs, then MEM load on rs the next cycle → 2 WAIT cycles; resolves with the register-file value 0x7 → taken.
- BLTZAL, rs=0x8000_0000 via MEM forward, pc_plus4=0x0040_0004 → taken, `link_we`=1, `link_data`=0x0040_0008.
- BGEZ with `id_imm`=0x8000, pc_plus4=0x0000_0010 → `br_target`=0xFFFE_0010 (wrap check).
- `resetn` low during WAIT → outputs 0 immediately; no pulse after release; the next branch resolves normally.
